// File: rtl/regfile_bist_pkg.sv
// Shared types, widths and the test pattern generator for the register-file BIST.
package regfile_bist_pkg;

  localparam int unsigned ERRW  = 6;
  localparam int unsigned REGW  = 5;
  localparam int unsigned DATAW = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    RADDR = 3'd2,
    RCHK  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Pass 0 writes seed+r, pass 1 writes its complement so every bit sees both values.
  function automatic logic [DATAW-1:0] pattern(input logic [DATAW-1:0] seed,
                                               input logic [REGW-1:0]  r,
                                               input logic             pass);
    logic [DATAW-1:0] base;
    base = seed + DATAW'(r);
    return pass ? ~base : base;
  endfunction

endpackage

// File: rtl/regfile_bist_cmp.sv
// Dual read-port comparator: flags each mismatching port and sums them.
module regfile_bist_cmp
  import regfile_bist_pkg::*;
(
  input  logic [DATAW-1:0] data1,
  input  logic [DATAW-1:0] data2,
  input  logic [DATAW-1:0] exp1,
  input  logic [DATAW-1:0] exp2,
  output logic             mismatch1_c,
  output logic             mismatch2_c,
  output logic [1:0]       inc_c
);

  assign mismatch1_c = (data1 != exp1);
  assign mismatch2_c = (data2 != exp2);
  assign inc_c       = 2'(mismatch1_c) + 2'(mismatch2_c);

endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST master: writes a pattern over a register range, reads it back
// two registers per access, then repeats with the inverted pattern.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int unsigned      FIRST_REG = 8,
  parameter int unsigned      LAST_REG  = 25,
  parameter logic [DATAW-1:0] SEED      = 32'h0000_0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERRW-1:0]  ErrCount,
  output logic [REGW-1:0]  FailReg,
  output logic [REGW-1:0]  ReadRegister1,
  output logic [REGW-1:0]  ReadRegister2,
  output logic [REGW-1:0]  WriteRegister,
  output logic [DATAW-1:0] WriteData,
  output logic             RegWrite,
  input  logic [DATAW-1:0] ReadData1,
  input  logic [DATAW-1:0] ReadData2
);

  // One spare bit so the read index can step past LAST_REG without wrapping.
  localparam int unsigned   RW      = REGW + 1;
  localparam int unsigned   ESW     = ERRW + 1;
  localparam logic [RW-1:0] FIRST_R = RW'(FIRST_REG);
  localparam logic [RW-1:0] LAST_R  = RW'(LAST_REG);

  state_t           state, nxt_state;
  logic [RW-1:0]    r, nxt_r, r_step;
  logic             pass, nxt_pass;
  logic             start_ok;
  logic [REGW-1:0]  nxt_rd2;
  logic [DATAW-1:0] exp1, exp2;
  logic             mismatch1, mismatch2;
  logic [1:0]       inc;
  logic [ESW-1:0]   err_sum;
  logic [ERRW-1:0]  err_next;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      r     <= '0;
      pass  <= 1'b0;
    end else begin
      state <= nxt_state;
      r     <= nxt_r;
      pass  <= nxt_pass;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_r     = r;
    nxt_pass  = pass;
    start_ok  = 1'b0;
    r_step    = r + RW'(2);
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          start_ok  = 1'b1;
          nxt_state = WRITE;
          nxt_r     = FIRST_R;
          nxt_pass  = 1'b0;
        end
      end
      WRITE: begin
        if (r == LAST_R) begin
          nxt_state = RADDR;
          nxt_r     = FIRST_R;
        end else begin
          nxt_r = r + RW'(1);
        end
      end
      RADDR: nxt_state = RCHK;
      RCHK: begin
        nxt_r = r_step;
        if (r_step > LAST_R) begin
          if (!pass) begin
            nxt_pass  = 1'b1;
            nxt_r     = FIRST_R;
            nxt_state = WRITE;
          end else begin
            nxt_state = DONE;
          end
        end else begin
          nxt_state = RADDR;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Port 2 reads the next register, clamped so an odd range ends on (LAST, LAST).
  always_comb begin
    nxt_rd2  = (nxt_r >= LAST_R) ? REGW'(LAST_R) : REGW'(nxt_r + RW'(1));
    exp1     = pattern(SEED, r[REGW-1:0], pass);
    exp2     = pattern(SEED, ReadRegister2, pass);
    err_sum  = ESW'(ErrCount) + ESW'(inc);
    err_next = err_sum[ERRW] ? '1 : err_sum[ERRW-1:0];
  end

  regfile_bist_cmp u_cmp (
    .data1       (ReadData1),
    .data2       (ReadData2),
    .exp1        (exp1),
    .exp2        (exp2),
    .mismatch1_c (mismatch1),
    .mismatch2_c (mismatch2),
    .inc_c       (inc)
  );

  // Register-file drive follows the upcoming state so it lines up with that state's cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      ReadRegister1 <= '0;
      ReadRegister2 <= '0;
    end else begin
      RegWrite <= (nxt_state == WRITE);
      if (nxt_state == WRITE) begin
        WriteRegister <= nxt_r[REGW-1:0];
        WriteData     <= pattern(SEED, nxt_r[REGW-1:0], nxt_pass);
      end
      if (nxt_state == RADDR) begin
        ReadRegister1 <= nxt_r[REGW-1:0];
        ReadRegister2 <= nxt_rd2;
      end
    end
  end

  // Status and error reporting.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      ErrCount <= '0;
      FailReg  <= '0;
    end else if (start_ok) begin
      Busy     <= 1'b1;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      ErrCount <= '0;
      FailReg  <= '0;
    end else if (state == RCHK) begin
      ErrCount <= err_next;
      if ((ErrCount == '0) && (inc != 2'd0)) begin
        FailReg <= mismatch1 ? r[REGW-1:0] : ReadRegister2;
      end
    end else if (state == DONE) begin
      Busy <= 1'b0;
      Done <= 1'b1;
      Pass <= (ErrCount == '0);
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench: two BIST instances, each against a behavioural register file with optional faults.
module tb_regfile_bist;

  logic        Clk;
  logic        Reset;
  int          total;
  int          bad;
  int          fault;

  logic        start_a, busy_a, done_a, pass_a, we_a;
  logic [5:0]  err_a;
  logic [4:0]  fail_a, rr1_a, rr2_a, wr_a;
  logic [31:0] wd_a, rd1_a, rd2_a;
  logic [31:0] rf_a [32] = '{default: 32'h0};

  logic        start_b, busy_b, done_b, pass_b, we_b;
  logic [5:0]  err_b;
  logic [4:0]  fail_b, rr1_b, rr2_b, wr_b;
  logic [31:0] wd_b, rd1_b, rd2_b;
  logic [31:0] rf_b [32] = '{default: 32'h0};

  regfile_bist dut_a (
    .Clk(Clk), .Reset(Reset), .Start(start_a), .Busy(busy_a), .Done(done_a),
    .Pass(pass_a), .ErrCount(err_a), .FailReg(fail_a), .ReadRegister1(rr1_a),
    .ReadRegister2(rr2_a), .WriteRegister(wr_a), .WriteData(wd_a), .RegWrite(we_a),
    .ReadData1(rd1_a), .ReadData2(rd2_a)
  );

  regfile_bist #(.FIRST_REG(8), .LAST_REG(24), .SEED(32'hA5A5_0000)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(start_b), .Busy(busy_b), .Done(done_b),
    .Pass(pass_b), .ErrCount(err_b), .FailReg(fail_b), .ReadRegister1(rr1_b),
    .ReadRegister2(rr2_b), .WriteRegister(wr_b), .WriteData(wd_b), .RegWrite(we_b),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Register file A: fault 1 = bit 3 of reg 12 stuck at 0, fault 2 = reg 25 ignores writes.
  always @(posedge Clk)
    if (we_a && wr_a != 5'd0 && !(fault == 2 && wr_a == 5'd25)) rf_a[wr_a] <= wd_a;

  always_comb begin
    rd1_a = (rr1_a == 5'd0) ? 32'h0 : rf_a[rr1_a];
    rd2_a = (rr2_a == 5'd0) ? 32'h0 : rf_a[rr2_a];
    if (fault == 1 && rr1_a == 5'd12) rd1_a = rd1_a & ~32'h8;
    if (fault == 1 && rr2_a == 5'd12) rd2_a = rd2_a & ~32'h8;
    if (fault == 2 && rr1_a == 5'd25) rd1_a = 32'h0;
    if (fault == 2 && rr2_a == 5'd25) rd2_a = 32'h0;
  end

  always @(posedge Clk)
    if (we_b && wr_b != 5'd0) rf_b[wr_b] <= wd_b;

  always_comb begin
    rd1_b = (rr1_b == 5'd0) ? 32'h0 : rf_b[rr1_b];
    rd2_b = (rr2_b == 5'd0) ? 32'h0 : rf_b[rr2_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int flt;
    bit sb;
    int err;
    int fail;
    bit pas;
  } vec_t;

  // One full run on DUT A; sb pulses Start mid-run, which must be ignored.
  task automatic run_a(input vec_t v);
    int done_at, nw, busy_low;
    done_at = -1; nw = 0; busy_low = 0;
    fault = v.flt;
    @(negedge Clk);
    start_a = 1'b1;
    @(negedge Clk);
    start_a = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge Clk);
      if (v.sb && k == 19) start_a = 1'b1;
      if (v.sb && k == 20) start_a = 1'b0;
      if (k == 0) begin
        chk("first_wreg", 32'(wr_a), 32'd8);
        chk("first_wdata", wd_a, 32'h8);
        chk("done_cleared", 32'(done_a), 32'd0);
        chk("err_cleared", 32'(err_a), 32'd0);
        chk("fail_cleared", 32'(fail_a), 32'd0);
      end
      if (we_a) nw++;
      if (done_a) begin
        done_at = k;
        break;
      end
      if (!busy_a) busy_low++;
    end
    chk("done_edge", done_at, 32'd73);
    chk("regwrite_cycles", nw, 32'd36);
    chk("busy_gaps", busy_low, 32'd0);
    chk("busy_at_done", 32'(busy_a), 32'd0);
    chk("pass", 32'(pass_a), 32'(v.pas));
    chk("errcount", 32'(err_a), 32'(v.err));
    chk("failreg", 32'(fail_a), 32'(v.fail));
  endtask

  vec_t vecs [4];

  initial begin
    int done_b_at;
    total = 0; bad = 0; fault = 0;
    start_a = 1'b0; start_b = 1'b0;
    Reset = 1'b0;
    vecs[0] = '{flt: 0, sb: 1'b0, err: 0, fail: 0,  pas: 1'b1};
    vecs[1] = '{flt: 1, sb: 1'b0, err: 1, fail: 12, pas: 1'b0};
    vecs[2] = '{flt: 2, sb: 1'b1, err: 2, fail: 25, pas: 1'b0};
    vecs[3] = '{flt: 0, sb: 1'b1, err: 0, fail: 0,  pas: 1'b1};
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_regwrite", 32'(we_a), 32'd0);
    Reset = 1'b1;

    foreach (vecs[i]) run_a(vecs[i]);
    chk("reg12_final", rf_a[12], 32'hFFFF_FFF3);

    // Abandon a run with an asynchronous reset during the write phase.
    fault = 0;
    @(negedge Clk);
    start_a = 1'b1;
    @(negedge Clk);
    start_a = 1'b0;
    repeat (5) @(negedge Clk);
    chk("mid_write", 32'(we_a), 32'd1);
    Reset = 1'b0;
    #1;
    chk("arst_regwrite", 32'(we_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_wreg", 32'(wr_a), 32'd0);
    chk("arst_wdata", wd_a, 32'd0);
    chk("arst_done", 32'(done_a), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    run_a(vecs[0]);

    // Odd range on DUT B: final pair reads (24, 24).
    done_b_at = -1;
    @(negedge Clk);
    start_b = 1'b1;
    @(negedge Clk);
    start_b = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge Clk);
      if (done_b) begin
        done_b_at = k;
        break;
      end
    end
    chk("b_done_edge", done_b_at, 32'd71);
    chk("b_pass", 32'(pass_b), 32'd1);
    chk("b_errcount", 32'(err_b), 32'd0);
    chk("b_last_rr1", 32'(rr1_b), 32'd24);
    chk("b_last_rr2", 32'(rr2_b), 32'd24);
    chk("b_reg24", rf_b[24], 32'h5A5A_FFE7);
    chk("b_reg25_untouched", rf_b[25], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
Name: regfile_bist

Overview:
- Built-in self-test master for the 32x32 RegisterFile; drives its write and dual-read ports from the opposite side of that interface.
- Writes a data pattern into a register range, then reads the range back two registers per access and compares against expected values.
- A second pass repeats the write and read-back with the inverted pattern.
- Reports Busy, Done, Pass, an error count and the first failing register; sits beside the datapath for bring-up and post-reset checks.

Parameters:
- FIRST_REG, 8, first register tested; legal range 1..31, so $zero is never written.
- LAST_REG, 25, last register tested; must be >= FIRST_REG.
- SEED, 32'h0000_0000, pattern base value.

Ports:
- Clk  in  1  system clock, rising-edge active.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a test; sampled only in IDLE or DONE.
- Busy  out  1  high while a test is running.
- Done  out  1  high from test completion until the next accepted Start.
- Pass  out  1  high with Done when ErrCount == 0.
- ErrCount  out  6  number of port mismatches; saturates at 63.
- FailReg  out  5  register number of the first mismatch.
- ReadRegister1  out  5  register file read address, port 1.
- ReadRegister2  out  5  register file read address, port 2.
- WriteRegister  out  5  register file write address.
- WriteData  out  32  register file write data.
- RegWrite  out  1  register file write enable.
- ReadData1  in  32  register file read data, port 1.
- ReadData2  in  32  register file read data, port 2.

Behaviour:
- Reset low (asynchronous): every output goes to 0 immediately, RegWrite included. State returns to IDLE.
- Reset mid-test: the test is abandoned, with no partial report.
- Pattern for register r: P0(r) = SEED + r (32-bit wrap) in pass 0; P1(r) = ~(SEED + r) in pass 1.
- N = LAST_REG - FIRST_REG + 1.
- States:
  - IDLE: Start=1 at a rising edge -> WRITE. At that same edge r=FIRST_REG, pass=0, ErrCount=0, FailReg=0, Done=0, Busy=1.
  - WRITE: each cycle drives RegWrite=1, WriteRegister=r, WriteData=Ppass(r); r increments at the edge. After the edge with r=LAST_REG: RegWrite=0, r=FIRST_REG, next state RADDR.
  - RADDR: drives ReadRegister1=r and ReadRegister2=min(r+1, LAST_REG) for one settle cycle. Next state RCHK.
  - RCHK: addresses held. At the edge, compares ReadData1 with Ppass(r) and ReadData2 with Ppass(ReadRegister2).
    - Each mismatching port adds 1 to ErrCount.
    - On the first mismatch, FailReg takes the failing register; port 1 has priority when both ports fail in the same check.
    - r += 2. If r > LAST_REG after the step: pass 0 -> pass=1, r=FIRST_REG, next state WRITE; pass 1 -> next state DONE. Otherwise -> RADDR.
  - DONE: Busy=0, Done=1, Pass=(ErrCount==0), all held. Start=1 -> WRITE, with the same initialisation as from IDLE.
- Odd N: the final pair reads LAST_REG on both ports, and both ports are checked.
- Start while Busy is ignored.
- RegWrite is never high outside WRITE.
- Latency: Done rises 2*(N + 2*ceil(N/2)) + 1 rising edges after the accepted Start edge, i.e. 73 for the defaults.
- RegisterFile semantics relied upon: write commits at the rising edge where RegWrite=1; read data is valid within one cycle of the address changing.

Decomposition:
- Package regfile_bist_pkg holds:
  - the state enum (IDLE, WRITE, RADDR, RCHK, DONE);
  - the ERRW=6 constant;
  - function pattern(seed, r, pass) returning P0/P1.
- One sub-module, regfile_bist_cmp: combinational dual comparator producing mismatch1, mismatch2 and the increment value (0..2). The FSM, counters and outputs live in the top.

Test Plan:
- Defaults, behavioural fault-free RegisterFile; Start pulse -> Busy for the run, Done and Pass at edge 73, ErrCount=0, RegWrite high for exactly 36 cycles, reg 12 holds 32'hFFFF_FFF3 at the end.
- Model with bit 3 of reg 12 stuck at 0 -> P0(12)=0xC mismatches, P1 passes; final ErrCount=1, FailReg=12, Pass=0.
- Model ignoring writes to reg 25 (reads 0) -> port-2 mismatch in both passes; ErrCount=2, FailReg=25.
- Reset dropped during WRITE at cycle 5 -> RegWrite, Busy and all outputs 0 within the same cycle. After release, Start restarts at WriteRegister=8 and completes with Pass=1.
- Start pulsed while Busy -> ignored, Done still at edge 73. Start in DONE -> Done clears next edge, ErrCount and FailReg reset, second run completes.
- FIRST_REG=8, LAST_REG=24, SEED=32'hA5A5_0000 -> last read pair is (24,24); Done at edge 2*(17+18)+1=71 with Pass=1.
